// File: rtl/baopoco_adc_power_acc.sv
// ADC power integrator: squares each demuxed sample, sums the lanes per clock and
// accumulates over a programmable number of valid clocks with saturation.
module baopoco_adc_power_acc #(
  parameter int N_SAMP = 4,
  parameter int SAMP_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 32
) (
  input  logic                       user_clk,
  input  logic                       user_rst,
  input  logic [N_SAMP*SAMP_W-1:0]   adc_data,
  input  logic                       adc_valid,
  input  logic                       sync_in,
  input  logic [CNT_W-1:0]           acc_len,
  output logic [ACC_W-1:0]           sum_out,
  output logic                       sum_valid,
  output logic                       overflow,
  output logic [31:0]                dump_count
);

  localparam int SQ_W = 2*SAMP_W - 1;
  localparam int P2_W = SQ_W + $clog2(N_SAMP);

  typedef enum logic {IDLE, ACCUM} state_t;

  logic [SQ_W-1:0]  sq_d [N_SAMP];
  logic [SQ_W-1:0]  sq_q [N_SAMP];
  logic             v1_q, s1_q;
  logic [P2_W-1:0]  p2_d, p2_q;
  logic             v2_q, s2_q;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sticky_q, sticky_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      dump_count_q, dump_count_d;

  // The square of a SAMP_W-bit signed value always fits in 2*SAMP_W-1 bits.
  for (genvar gi = 0; gi < N_SAMP; gi++) begin : g_sq
    logic signed [SAMP_W-1:0] samp;
    assign samp     = adc_data[gi*SAMP_W +: SAMP_W];
    assign sq_d[gi] = SQ_W'(samp * samp);
  end

  always_comb begin
    p2_d = '0;
    for (int i = 0; i < N_SAMP; i++) begin
      p2_d = p2_d + P2_W'(sq_q[i]);
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      v1_q <= 1'b0;
      s1_q <= 1'b0;
      v2_q <= 1'b0;
      s2_q <= 1'b0;
      p2_q <= '0;
      for (int i = 0; i < N_SAMP; i++) sq_q[i] <= '0;
    end else begin
      v1_q <= adc_valid;
      s1_q <= sync_in;
      v2_q <= v1_q;
      s2_q <= s1_q;
      p2_q <= p2_d;
      for (int i = 0; i < N_SAMP; i++) sq_q[i] <= sq_d[i];
    end
  end

  logic               active;
  logic [ACC_W-1:0]   base_acc;
  logic [CNT_W-1:0]   base_cnt;
  logic               base_sticky;
  logic [CNT_W-1:0]   len_new, len_eff;
  logic [ACC_W:0]     sum_ext;
  logic               sat_now;
  logic [ACC_W-1:0]   acc_add;
  logic               dump;

  // A sync discards the partial integration; its coincident sample starts the new one.
  always_comb begin
    active      = s2_q || (state_q == ACCUM);
    base_acc    = s2_q ? '0 : acc_q;
    base_cnt    = s2_q ? '0 : cnt_q;
    base_sticky = s2_q ? 1'b0 : sticky_q;
    len_new     = (acc_len == '0) ? CNT_W'(1) : acc_len;
    len_eff     = (base_cnt == '0) ? len_new : len_q;
    sum_ext     = {1'b0, base_acc} + (ACC_W+1)'(p2_q);
    sat_now     = sum_ext[ACC_W];
    acc_add     = sat_now ? '1 : sum_ext[ACC_W-1:0];
    dump        = active && v2_q && (base_cnt == len_eff - CNT_W'(1));

    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    sticky_d     = sticky_q;
    sum_d        = sum_q;
    sum_valid_d  = 1'b0;
    overflow_d   = overflow_q;
    dump_count_d = dump_count_q;

    if (s2_q) begin
      state_d  = ACCUM;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end

    if (active && v2_q) begin
      if (base_cnt == '0) len_d = len_new;
      if (dump) begin
        sum_d        = acc_add;
        overflow_d   = base_sticky | sat_now;
        sum_valid_d  = 1'b1;
        dump_count_d = dump_count_q + 32'd1;
        acc_d        = '0;
        cnt_d        = '0;
        sticky_d     = 1'b0;
      end else begin
        acc_d    = acc_add;
        cnt_d    = base_cnt + CNT_W'(1);
        sticky_d = base_sticky | sat_now;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= CNT_W'(1);
      sticky_q     <= 1'b0;
      sum_q        <= '0;
      sum_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      dump_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      sticky_q     <= sticky_d;
      sum_q        <= sum_d;
      sum_valid_q  <= sum_valid_d;
      overflow_q   <= overflow_d;
      dump_count_q <= dump_count_d;
    end
  end

  assign sum_out    = sum_q;
  assign sum_valid  = sum_valid_q;
  assign overflow   = overflow_q;
  assign dump_count = dump_count_q;

endmodule

// File: tb/tb_baopoco_adc_power_acc.sv
// Directed bench for baopoco_adc_power_acc: a default instance plus a 20-bit
// accumulator instance sharing the same stimulus.
module tb_baopoco_adc_power_acc;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic        sync_in;
  logic [31:0] acc_len;

  logic [31:0] sum_out;
  logic        sum_valid;
  logic        overflow;
  logic [31:0] dump_count;

  logic [19:0] sum_out20;
  logic        sum_valid20;
  logic        overflow20;
  logic [31:0] dump_count20;

  int tests = 0;
  int fails = 0;

  always #5 user_clk = ~user_clk;

  baopoco_adc_power_acc dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .sync_in    (sync_in),
    .acc_len    (acc_len),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .overflow   (overflow),
    .dump_count (dump_count)
  );

  baopoco_adc_power_acc #(.ACC_W(20)) dut20 (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .sync_in    (sync_in),
    .acc_len    (acc_len),
    .sum_out    (sum_out20),
    .sum_valid  (sum_valid20),
    .overflow   (overflow20),
    .dump_count (dump_count20)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic set_samp(input logic [7:0] v);
    adc_data = {4{v}};
  endtask

  // Reset, then one sync with no valid data; the next step is sample step 1.
  task automatic start_run();
    user_rst  = 1'b1;
    adc_valid = 1'b0;
    sync_in   = 1'b0;
    step();
    user_rst = 1'b0;
    sync_in  = 1'b1;
    step();
    sync_in = 1'b0;
  endtask

  initial begin
    int  pulses;
    int  k;
    bit  exp_sv;

    // Reset, then data without sync
    user_rst  = 1'b1;
    adc_valid = 1'b0;
    sync_in   = 1'b0;
    acc_len   = 32'd4;
    set_samp(8'd1);
    step();
    step();
    check("rst_sum_out", sum_out, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dump_count", dump_count, 0);
    user_rst  = 1'b0;
    adc_valid = 1'b1;
    pulses    = 0;
    repeat (100) begin
      step();
      if (sum_valid) pulses++;
    end
    check("nosync_pulses", pulses, 0);
    check("nosync_sum_out", sum_out, 0);

    // acc_len=4, samples +1: 16 every 4 clocks, first pulse 2 steps after sample 4
    acc_len = 32'd4;
    set_samp(8'd1);
    start_run();
    adc_valid = 1'b1;
    k = 0;
    for (int i = 1; i <= 18; i++) begin
      step();
      exp_sv = (i >= 6) && ((i - 6) % 4 == 0);
      check("len4_sum_valid", sum_valid, exp_sv);
      if (i == 5) check("len4_pre_sum_out", sum_out, 0);
      if (exp_sv) begin
        k++;
        check("len4_sum_out", sum_out, 16);
        check("len4_dump_count", dump_count, k);
      end
    end

    // acc_len=1 with -128 samples, then acc_len=0 treated as 1
    acc_len = 32'd1;
    set_samp(8'h80);
    start_run();
    adc_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i >= 3) begin
        check("len1_sum_valid", sum_valid, 1);
        check("len1_sum_out", sum_out, 65536);
      end
    end
    acc_len = 32'd0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i >= 3) begin
        check("len0_sum_valid", sum_valid, 1);
        check("len0_sum_out", sum_out, 65536);
      end
    end

    // 20-bit accumulator saturates over 32 x 65536, then a zero integration clears overflow
    acc_len = 32'd32;
    set_samp(8'h80);
    start_run();
    adc_valid = 1'b1;
    for (int i = 1; i <= 66; i++) begin
      step();
      if (i == 32) set_samp(8'd0);
      if (i == 33) check("sat_early_sum_valid", sum_valid20, 0);
      if (i == 34) begin
        check("sat_sum_valid", sum_valid20, 1);
        check("sat_sum_out", sum_out20, 20'hFFFFF);
        check("sat_overflow", overflow20, 1);
        check("wide_sum_out", sum_out, 2097152);
        check("wide_overflow", overflow, 0);
      end
      if (i == 65) check("sat_hold_sum_out", sum_out20, 20'hFFFFF);
      if (i == 66) begin
        check("zero_sum_valid", sum_valid20, 1);
        check("zero_sum_out", sum_out20, 0);
        check("zero_overflow", overflow20, 0);
      end
    end

    // Toggling valid: dump every 8 clocks; sync after 2 valids restarts the count
    acc_len = 32'd4;
    set_samp(8'd2);
    start_run();
    for (int i = 1; i <= 32; i++) begin
      adc_valid = (i % 2 == 1);
      sync_in   = (i == 20);
      step();
      exp_sv = (i == 9) || (i == 17) || (i == 29);
      check("toggle_sum_valid", sum_valid, exp_sv);
      if (exp_sv) check("toggle_sum_out", sum_out, 64);
    end
    sync_in = 1'b0;
    check("toggle_dump_count", dump_count, 3);

    // Sync coincident with the would-be dump sample suppresses that dump
    acc_len = 32'd4;
    set_samp(8'd1);
    start_run();
    adc_valid = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      sync_in = (i == 8);
      step();
      exp_sv = (i == 6) || (i == 13);
      check("syncdump_sum_valid", sum_valid, exp_sv);
      if (i == 10) begin
        check("syncdump_hold_sum_out", sum_out, 16);
        check("syncdump_hold_count", dump_count, 1);
      end
      if (i == 13) check("syncdump_count", dump_count, 2);
    end
    sync_in = 1'b0;

    // Reset mid-integration returns to reset values and waits for a new sync
    step();
    step();
    user_rst = 1'b1;
    step();
    check("midrst_sum_out", sum_out, 0);
    check("midrst_sum_valid", sum_valid, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_dump_count", dump_count, 0);
    user_rst = 1'b0;
    pulses   = 0;
    repeat (12) begin
      step();
      if (sum_valid) pulses++;
    end
    check("midrst_nosync_pulses", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/baopoco_adc_power_acc.md
Name: baopoco_adc_power_acc

Overview:
- Integrates ADC power: squares each demuxed ADC sample, sums the squares per clock and accumulates over a programmable number of valid clocks.
- Final integrated value is held on sum_out, which drives user_data_in of the downstream adc_sum OPB software register (simulink2ppc, 32-bit, user_clk domain).
- Sits between the ADC capture interface and the adc_sum register; one instance per ADC channel.

Parameters:
- N_SAMP, 4, parallel samples per clock (iADC demux factor).
- SAMP_W, 8, sample width, two's complement.
- ACC_W, 32, accumulator and sum_out width; must match the downstream register width.
- CNT_W, 32, width of acc_len and of the internal valid-clock counter.

Ports:
- user_clk  in  1  fabric clock; all logic is in this domain.
- user_rst  in  1  synchronous reset, active-high.
- adc_data  in  N_SAMP*SAMP_W  packed samples; sample i occupies bits [i*SAMP_W +: SAMP_W].
- adc_valid  in  1  adc_data is valid this clock.
- sync_in  in  1  one-clock pulse; restarts integration.
- acc_len  in  CNT_W  integration length in valid clocks; 0 is treated as 1.
- sum_out  out  ACC_W  last completed integration; drives the adc_sum register.
- sum_valid  out  1  one-clock pulse when sum_out updates.
- overflow  out  1  set when the value on sum_out saturated.
- dump_count  out  32  number of completed integrations; wraps.

Behaviour:
- Reset: sum_out=0, sum_valid=0, overflow=0, dump_count=0, accumulator=0, counter=0, pipeline valids cleared, state IDLE.
- P1 (registered): sq[i] = s[i]*s[i], unsigned, 2*SAMP_W-1 bits. Maximum is 16384 for -128. valid and sync are delayed alongside.
- P2 (registered): p2 = sum of sq[i], 2*SAMP_W-1+clog2(N_SAMP) bits (17 bits by default).
- P3 accumulator FSM:
  - IDLE: ignore data until a delayed sync reaches P3, then go to ACCUM.
  - ACCUM: on each P3 valid, acc += p2 and cnt += 1.
  - Dump occurs on a valid when cnt == len-1. The dump cycle does all of the following:
    - sum_out <= sat(acc+p2)
    - overflow <= sticky saturation flag OR saturation this cycle
    - sum_valid = 1 for one clock
    - dump_count += 1
    - acc, cnt and the sticky flag are cleared
- len latch: len = max(acc_len, 1), latched when cnt==0 and a valid arrives, i.e. at the first sample of each integration. A change to acc_len mid-integration takes effect at the next integration.
- Saturation: if acc+p2 > 2^ACC_W-1, acc clamps at 2^ACC_W-1 and the sticky flag is set. Accumulation continues clamped.
- Invalid P3 cycles: no add, no count, no dump.
- Sync in ACCUM: acc and cnt are cleared, the partial sum is discarded, and no dump occurs. The P3 sample coincident with sync (if valid) is the first sample of the new integration.
- Sync coincident with a would-be dump: sync wins. No sum_valid, and sum_out holds its old value.
- sum_out, overflow and dump_count hold between dumps. The downstream register samples them freely.
- dump_count wraps from 2^32-1 to 0.
- Latency: the last valid sample at the input in cycle t produces sum_valid and the new sum_out in cycle t+3.
- Reset mid-integration: everything returns to reset values and the block waits for a new sync.

Test Plan:
- Reset, then samples with no sync: sum_valid stays 0 and sum_out=0 for 100 clocks.
- acc_len=4, all samples +1, valid always high, one sync: sum_valid every 4 clocks, sum_out=16, dump_count increments 1,2,3; first pulse 3 clocks after the 4th post-sync sample.
- acc_len=1, samples -128: sum_out=65536 every clock. Then acc_len=0: same result (treated as 1).
- ACC_W=20, samples -128, acc_len=32: sum_out=0xFFFFF and overflow=1. Then samples 0: next dump gives sum_out=0, overflow=0.
- acc_len=4, samples +2 with adc_valid toggling 1,0,1,0: a dump every 8 clocks with sum_out=64. Sync asserted after 2 valids: no dump, and the next dump comes 4 valids after sync.
- Sync aligned exactly to the dump sample: no sum_valid, and sum_out keeps its prior value. Reset mid-integration: outputs return to 0.
